// File: rtl/mvu_apb_cfg_master.sv
// mvu_apb_cfg_master: queues MVU CSR requests and plays each one out as a
// single APB3 transfer (SETUP then ACCESS), returning one response per
// request in order. A stalled responder is cut off after TIMEOUT ACCESS
// cycles and answered with an error.
//
// Handshake: a request is taken on any rising clk edge where req_valid and
// req_ready are both high; req_ready depends only on queue fullness, never
// on req_valid. rsp_valid is a single-cycle pulse with no ready; the
// consumer must take it in that cycle.
module mvu_apb_cfg_master #(
  parameter int APB_ADDR_WIDTH = 15,
  parameter int APB_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT        = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // sequencer request port
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr,
  input  logic [APB_DATA_WIDTH-1:0] req_wdata,
  // response port
  output logic                      rsp_valid,
  output logic                      rsp_err,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata,
  output logic                      busy,
  // APB3 initiator
  output logic [APB_ADDR_WIDTH-1:0] paddr,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [APB_DATA_WIDTH-1:0] pwdata,
  input  logic [APB_DATA_WIDTH-1:0] prdata,
  input  logic                      pready,
  input  logic                      pslverr,
  // debug: current FSM state (0 = IDLE, 1 = SETUP, 2 = ACCESS)
  output logic [1:0]                dbg_state
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  // ---------------------------------------------------------------------
  // Request queue storage and pointers
  // ---------------------------------------------------------------------
  logic [FIFO_DEPTH-1:0][APB_ADDR_WIDTH-1:0] addr_mem_q, addr_mem_d;
  logic [FIFO_DEPTH-1:0][APB_DATA_WIDTH-1:0] wdata_mem_q, wdata_mem_d;
  logic [FIFO_DEPTH-1:0]                     write_mem_q, write_mem_d;
  logic [PTR_W-1:0]                          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]                          rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]                          count_q, count_d;

  logic [PTR_W-1:0] rd_ptr_nxt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             has_next;
  logic             push;
  logic             pop;

  // ---------------------------------------------------------------------
  // Transfer FSM and registered APB / response outputs
  // ---------------------------------------------------------------------
  state_e                    state_q, state_d;
  logic [TO_W-1:0]           to_cnt_q, to_cnt_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic                      pwrite_q, pwrite_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic                      rsp_err_q, rsp_err_d;
  logic [APB_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                      xfer_done;

  // Head entry (in flight while the FSM is busy) and the entry behind it,
  // which is what a back-to-back reload picks up at completion.
  logic [APB_ADDR_WIDTH-1:0] head_addr, next_addr;
  logic [APB_DATA_WIDTH-1:0] head_wdata, next_wdata;
  logic                      head_write, next_write;

  // Queue status and entry selection
  always_comb begin
    rd_ptr_nxt = rd_ptr_q + PTR_W'(1);
    fifo_full  = (count_q == DEPTH_C);
    fifo_empty = (count_q == '0);
    has_next   = (count_q > CNT_W'(1));
    push       = req_valid && !fifo_full;
    head_addr  = addr_mem_q[rd_ptr_q];
    head_wdata = wdata_mem_q[rd_ptr_q];
    head_write = write_mem_q[rd_ptr_q];
    next_addr  = addr_mem_q[rd_ptr_nxt];
    next_wdata = wdata_mem_q[rd_ptr_nxt];
    next_write = write_mem_q[rd_ptr_nxt];
  end

  // Queue update: write at wr_ptr on push, advance rd_ptr on pop; the head
  // stays in the queue until its transfer completes or is aborted.
  always_comb begin
    addr_mem_d  = addr_mem_q;
    wdata_mem_d = wdata_mem_q;
    write_mem_d = write_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (push) begin
      addr_mem_d[wr_ptr_q]  = req_addr;
      wdata_mem_d[wr_ptr_q] = req_wdata;
      write_mem_d[wr_ptr_q] = req_write;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_nxt;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Queue registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_mem_q  <= '0;
      wdata_mem_q <= '0;
      write_mem_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      addr_mem_q  <= addr_mem_d;
      wdata_mem_q <= wdata_mem_d;
      write_mem_q <= write_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Next-state and output logic: APB outputs only move on IDLE->SETUP,
  // SETUP->ACCESS and at completion/abort; pready wins over the timeout in
  // the last allowed ACCESS cycle.
  always_comb begin
    state_d     = state_q;
    to_cnt_d    = to_cnt_q;
    paddr_d     = paddr_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    xfer_done   = 1'b0;
    pop         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          paddr_d   = head_addr;
          pwrite_d  = head_write;
          pwdata_d  = head_write ? head_wdata : '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = ST_SETUP;
        end
      end

      ST_SETUP: begin
        penable_d = 1'b1;
        to_cnt_d  = '0;
        state_d   = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (pready) begin
          xfer_done   = 1'b1;
          rsp_err_d   = pslverr;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
        end else if (to_cnt_q == TO_LAST) begin
          xfer_done   = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end

        if (xfer_done) begin
          pop         = 1'b1;
          rsp_valid_d = 1'b1;
          to_cnt_d    = '0;
          if (has_next) begin
            paddr_d   = next_addr;
            pwrite_d  = next_write;
            pwdata_d  = next_write ? next_wdata : '0;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            state_d   = ST_SETUP;
          end else begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            state_d   = ST_IDLE;
          end
        end
      end

      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        to_cnt_d  = '0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // FSM, APB and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      to_cnt_q    <= '0;
      paddr_q     <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      paddr_q     <= paddr_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Output mapping
  always_comb begin
    req_ready = !fifo_full;
    busy      = !fifo_empty || (state_q != ST_IDLE);
    paddr     = paddr_q;
    psel      = psel_q;
    penable   = penable_q;
    pwrite    = pwrite_q;
    pwdata    = pwdata_q;
    rsp_valid = rsp_valid_q;
    rsp_err   = rsp_err_q;
    rsp_rdata = rsp_rdata_q;
    dbg_state = state_q;
  end

endmodule
